// File: rtl/hdmi_src_arbiter_pkg.sv
// Shared types and constants for the frame-aligned 2:1 HDMI source arbiter.
package hdmi_src_arbiter_pkg;

    // Active lines per frame for CEA-861-D 1080p30; matches the timing-generator package.
    localparam int unsigned ACTIVE_LINES = 1080;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        SEEK_S = 2'd1,
        FWD_S  = 2'd2
    } arb_state_e;

    // Width of a counter that can hold 0..lines inclusive.
    function automatic int unsigned line_cnt_width(input int unsigned lines);
        return $clog2(lines + 1);
    endfunction

endpackage

// File: rtl/hdmi_src_arbiter_axis_mux2.sv
// Combinational 2:1 AXI4-Stream mux with a forward/drop control for the
// selected input and a fixed ready level for the non-selected input.
module hdmi_src_arbiter_axis_mux2 #(
    parameter int unsigned DATA_W = 30
) (
    input  logic              sel,
    input  logic              fwd,
    input  logic              drop,
    input  logic              unsel_ready,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic              s0_tuser,
    input  logic              s0_tlast,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic              s1_tuser,
    input  logic              s1_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast
);

    logic act_ready;

    // Payload sidebands are not gated so the caller can inspect tuser before deciding to forward.
    assign m_tdata  = sel ? s1_tdata : s0_tdata;
    assign m_tuser  = sel ? s1_tuser : s0_tuser;
    assign m_tlast  = sel ? s1_tlast : s0_tlast;
    assign m_tvalid = (sel ? s1_tvalid : s0_tvalid) & fwd;

    // Dropped beats are accepted locally; forwarded beats follow downstream ready.
    assign act_ready = drop | (fwd & m_tready);
    assign s0_tready = sel ? unsel_ready : act_ready;
    assign s1_tready = sel ? act_ready : unsel_ready;

endmodule

// File: rtl/hdmi_src_arbiter.sv
// Frame-aligned 2:1 video source arbiter. Switches sources only on frame
// boundaries, hunts for start-of-frame after a switch, counts mid-frame SOFs.
module hdmi_src_arbiter
    import hdmi_src_arbiter_pkg::*;
#(
    parameter int unsigned PX_WIDTH    = 10,
    parameter int unsigned FRAME_LINES = ACTIVE_LINES,
    parameter bit          DRAIN_UNSEL = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PX_WIDTH*3-1:0]   video_0_tdata,
    input  logic                    video_0_tvalid,
    output logic                    video_0_tready,
    input  logic                    video_0_tuser,
    input  logic                    video_0_tlast,
    input  logic [PX_WIDTH*3-1:0]   video_1_tdata,
    input  logic                    video_1_tvalid,
    output logic                    video_1_tready,
    input  logic                    video_1_tuser,
    input  logic                    video_1_tlast,
    output logic [PX_WIDTH*3-1:0]   video_o_tdata,
    output logic                    video_o_tvalid,
    input  logic                    video_o_tready,
    output logic                    video_o_tuser,
    output logic                    video_o_tlast,
    input  logic                    sel_i,
    output logic                    active_src_o,
    output logic                    locked_o,
    output logic                    switch_o,
    output logic [15:0]             sof_err_cnt_o
);

    localparam int unsigned CNT_W = line_cnt_width(FRAME_LINES);
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(FRAME_LINES - 1);

    arb_state_e        state, state_nxt;
    logic [CNT_W-1:0]  line_cnt, line_nxt, base_cnt;
    logic              active_src, src_nxt;
    logic              locked, locked_nxt;
    logic              switch_p, switch_nxt;
    logic [15:0]       err_cnt, err_nxt;
    logic              frame_end;
    logic              fwd, drop, unsel_ready;
    logic              hs;

    hdmi_src_arbiter_axis_mux2 #(
        .DATA_W (PX_WIDTH * 3)
    ) u_mux (
        .sel         (active_src),
        .fwd         (fwd),
        .drop        (drop),
        .unsel_ready (unsel_ready),
        .s0_tdata    (video_0_tdata),
        .s0_tvalid   (video_0_tvalid),
        .s0_tready   (video_0_tready),
        .s0_tuser    (video_0_tuser),
        .s0_tlast    (video_0_tlast),
        .s1_tdata    (video_1_tdata),
        .s1_tvalid   (video_1_tvalid),
        .s1_tready   (video_1_tready),
        .s1_tuser    (video_1_tuser),
        .s1_tlast    (video_1_tlast),
        .m_tdata     (video_o_tdata),
        .m_tvalid    (video_o_tvalid),
        .m_tready    (video_o_tready),
        .m_tuser     (video_o_tuser),
        .m_tlast     (video_o_tlast)
    );

    assign hs = video_o_tvalid & video_o_tready;

    // Mux control: in SEEK only a SOF beat is presented, everything else is dropped.
    always_comb begin
        fwd         = 1'b0;
        drop        = 1'b0;
        unsel_ready = 1'b0;
        unique case (state)
            SEEK_S: begin
                fwd         = video_o_tuser;
                drop        = ~video_o_tuser;
                unsel_ready = DRAIN_UNSEL;
            end
            FWD_S: begin
                fwd         = 1'b1;
                unsel_ready = DRAIN_UNSEL;
            end
            default: ;
        endcase
    end

    // Next state, line counting, frame-boundary source selection and SOF error counting.
    // A SOF handshake restarts the count from zero in both SEEK and FWD, so one path covers both.
    always_comb begin
        state_nxt  = state;
        line_nxt   = line_cnt;
        src_nxt    = active_src;
        switch_nxt = 1'b0;
        err_nxt    = err_cnt;
        base_cnt   = line_cnt;
        frame_end  = 1'b0;
        locked_nxt = 1'b0;
        if (state == IDLE_S) begin
            state_nxt = SEEK_S;
            src_nxt   = sel_i;
        end else if (hs) begin
            state_nxt = FWD_S;
            if (video_o_tuser) begin
                base_cnt = '0;
                if (state == FWD_S && err_cnt != '1) begin
                    err_nxt = err_cnt + 16'd1;
                end
            end
            if (video_o_tlast) begin
                if (base_cnt == LAST_LINE) begin
                    frame_end = 1'b1;
                end else begin
                    line_nxt = base_cnt + 1'b1;
                end
            end else begin
                line_nxt = base_cnt;
            end
        end
        if (frame_end) begin
            state_nxt  = SEEK_S;
            line_nxt   = '0;
            src_nxt    = sel_i;
            switch_nxt = (sel_i != active_src);
        end
        locked_nxt = (state_nxt == FWD_S);
    end

    // State and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE_S;
            line_cnt   <= '0;
            active_src <= 1'b0;
            locked     <= 1'b0;
            switch_p   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            line_cnt   <= line_nxt;
            active_src <= src_nxt;
            locked     <= locked_nxt;
            switch_p   <= switch_nxt;
            err_cnt    <= err_nxt;
        end
    end

    assign active_src_o  = active_src;
    assign locked_o      = locked;
    assign switch_o      = switch_p;
    assign sof_err_cnt_o = err_cnt;

endmodule

// File: tb/tb_hdmi_src_arbiter.sv
// Directed bench for hdmi_src_arbiter with 4-line frames of 2 beats per line.
// A second instance with DRAIN_UNSEL=0 shares all inputs to observe stalling.
module tb_hdmi_src_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [29:0] v0_tdata, v1_tdata;
    logic        v0_tvalid, v0_tuser, v0_tlast, v0_tready;
    logic        v1_tvalid, v1_tuser, v1_tlast, v1_tready;
    logic [29:0] o_tdata;
    logic        o_tvalid, o_tuser, o_tlast, o_tready;
    logic        active_src, locked, switch_p;
    logic [15:0] err_cnt;

    logic [29:0] s_o_tdata;
    logic        s_o_tvalid, s_o_tuser, s_o_tlast, s_v0_tready, s_v1_tready;
    logic        s_active, s_locked, s_switch;
    logic [15:0] s_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hdmi_src_arbiter #(
        .PX_WIDTH    (10),
        .FRAME_LINES (4),
        .DRAIN_UNSEL (1'b1)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .video_0_tdata  (v0_tdata),
        .video_0_tvalid (v0_tvalid),
        .video_0_tready (v0_tready),
        .video_0_tuser  (v0_tuser),
        .video_0_tlast  (v0_tlast),
        .video_1_tdata  (v1_tdata),
        .video_1_tvalid (v1_tvalid),
        .video_1_tready (v1_tready),
        .video_1_tuser  (v1_tuser),
        .video_1_tlast  (v1_tlast),
        .video_o_tdata  (o_tdata),
        .video_o_tvalid (o_tvalid),
        .video_o_tready (o_tready),
        .video_o_tuser  (o_tuser),
        .video_o_tlast  (o_tlast),
        .sel_i          (sel),
        .active_src_o   (active_src),
        .locked_o       (locked),
        .switch_o       (switch_p),
        .sof_err_cnt_o  (err_cnt)
    );

    hdmi_src_arbiter #(
        .PX_WIDTH    (10),
        .FRAME_LINES (4),
        .DRAIN_UNSEL (1'b0)
    ) u_stall (
        .clk_i          (clk),
        .rst_i          (rst),
        .video_0_tdata  (v0_tdata),
        .video_0_tvalid (v0_tvalid),
        .video_0_tready (s_v0_tready),
        .video_0_tuser  (v0_tuser),
        .video_0_tlast  (v0_tlast),
        .video_1_tdata  (v1_tdata),
        .video_1_tvalid (v1_tvalid),
        .video_1_tready (s_v1_tready),
        .video_1_tuser  (v1_tuser),
        .video_1_tlast  (v1_tlast),
        .video_o_tdata  (s_o_tdata),
        .video_o_tvalid (s_o_tvalid),
        .video_o_tready (o_tready),
        .video_o_tuser  (s_o_tuser),
        .video_o_tlast  (s_o_tlast),
        .sel_i          (sel),
        .active_src_o   (s_active),
        .locked_o       (s_locked),
        .switch_o       (s_switch),
        .sof_err_cnt_o  (s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [29:0] mk(input bit src, input int f, input int l, input int b);
        return {5'd0, src, 8'(f), 8'(l), 8'(b)};
    endfunction

    task automatic drive(input bit src, input bit v, input bit u, input bit l, input logic [29:0] d);
        if (src) begin
            v1_tvalid = v; v1_tuser = u; v1_tlast = l; v1_tdata = d; v0_tvalid = 1'b0;
        end else begin
            v0_tvalid = v; v0_tuser = u; v0_tlast = l; v0_tdata = d; v1_tvalid = 1'b0;
        end
    endtask

    // One beat with downstream ready high; fwd says whether it must appear on the output.
    task automatic beat(input bit src, input bit u, input bit l, input logic [29:0] d, input bit fwd);
        drive(src, 1'b1, u, l, d);
        #1;
        chk("out_tvalid", o_tvalid, fwd);
        if (fwd) begin
            chk("out_tdata", o_tdata, d);
            chk("out_tuser", o_tuser, u);
            chk("out_tlast", o_tlast, l);
            chk("drain_unsel_tready", src ? v0_tready : v1_tready, 1'b1);
            chk("stall_unsel_tready", src ? s_v0_tready : s_v1_tready, 1'b0);
            chk("stall_out_tdata", s_o_tdata, d);
            chk("stall_out_flags", {s_o_tvalid, s_o_tuser, s_o_tlast}, {1'b1, u, l});
        end
        chk("src_tready", src ? v1_tready : v0_tready, fwd ? o_tready : 1'b1);
        tick();
        drive(src, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic frame(input bit src, input int f, input bit sel_l1, input bit sel_l3);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 2; b++) begin
                if (b == 0 && l == 1) sel = sel_l1;
                if (b == 0 && l == 3) sel = sel_l3;
                beat(src, (l == 0 && b == 0), (b == 1), mk(src, f, l, b), 1'b1);
                if (l == 0 && b == 0) chk("locked_in_frame", locked, 1'b1);
            end
        end
        chk("locked_after_frame", locked, 1'b0);
    endtask

    initial begin
        logic [29:0] d;
        bit          hs;

        rst = 1'b1; sel = 1'b1; o_tready = 1'b1;
        v0_tdata = '0; v0_tvalid = 1'b0; v0_tuser = 1'b0; v0_tlast = 1'b0;
        v1_tdata = mk(1, 0, 0, 0); v1_tvalid = 1'b1; v1_tuser = 1'b1; v1_tlast = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_active_src", active_src, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_switch", switch_p, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'h0000);
        chk("rst_out_tvalid", o_tvalid, 1'b0);
        chk("rst_tready", {v0_tready, v1_tready, s_v0_tready, s_v1_tready}, 4'b0000);
        chk("rst_stall_status", {s_active, s_locked, s_switch, s_err}, 19'd0);

        // IDLE cycle after release: nothing accepted, no switch pulse when sel is loaded
        rst = 1'b0;
        #1;
        chk("idle_out_tvalid", o_tvalid, 1'b0);
        chk("idle_tready", {v0_tready, v1_tready}, 2'b00);
        v1_tvalid = 1'b0; v1_tuser = 1'b0;
        tick();
        chk("seek_active_src", active_src, 1'b1);
        chk("seek_no_switch", switch_p, 1'b0);

        // Three back-to-back frames from source 1; mid-frame toggles in frame 1 have no effect
        frame(1'b1, 0, 1'b1, 1'b1);
        chk("f0_active", active_src, 1'b1);
        frame(1'b1, 1, 1'b0, 1'b1);
        chk("f1_no_switch", switch_p, 1'b0);
        chk("f1_active", active_src, 1'b1);
        frame(1'b1, 2, 1'b1, 1'b0);
        chk("f2_switch_pulse", switch_p, 1'b1);
        chk("f2_active", active_src, 1'b0);
        chk("f2_err_cnt", err_cnt, 16'h0000);

        // Source 0 joins mid-frame: two lines dropped, output starts at the SOF
        beat(1'b0, 1'b0, 1'b0, mk(0, 9, 2, 0), 1'b0);
        chk("switch_one_cycle", switch_p, 1'b0);
        beat(1'b0, 1'b0, 1'b1, mk(0, 9, 2, 1), 1'b0);
        beat(1'b0, 1'b0, 1'b0, mk(0, 9, 3, 0), 1'b0);
        beat(1'b0, 1'b0, 1'b1, mk(0, 9, 3, 1), 1'b0);
        chk("drop_not_locked", locked, 1'b0);
        frame(1'b0, 3, 1'b0, 1'b0);
        chk("f3_active", active_src, 1'b0);

        // sel 0->1 at line 1 of a source-0 frame: frame finishes, then source 1's next SOF
        frame(1'b0, 4, 1'b1, 1'b1);
        chk("f4_switch_pulse", switch_p, 1'b1);
        chk("f4_active", active_src, 1'b1);
        beat(1'b0, 1'b1, 1'b0, mk(0, 5, 0, 0), 1'b0);
        chk("f4_switch_cleared", switch_p, 1'b0);
        beat(1'b1, 1'b0, 1'b1, mk(1, 9, 3, 1), 1'b0);
        frame(1'b1, 5, 1'b1, 1'b1);

        // tuser on line 2 (third line) with a simultaneous sel change
        beat(1'b1, 1'b1, 1'b0, mk(1, 6, 0, 0), 1'b1);
        beat(1'b1, 1'b0, 1'b1, mk(1, 6, 0, 1), 1'b1);
        beat(1'b1, 1'b0, 1'b0, mk(1, 6, 1, 0), 1'b1);
        beat(1'b1, 1'b0, 1'b1, mk(1, 6, 1, 1), 1'b1);
        sel = 1'b0;
        beat(1'b1, 1'b1, 1'b0, mk(1, 7, 0, 0), 1'b1);
        chk("inj_err_cnt", err_cnt, 16'h0001);
        chk("inj_no_switch", switch_p, 1'b0);
        chk("inj_active", active_src, 1'b1);
        chk("inj_locked", locked, 1'b1);
        beat(1'b1, 1'b0, 1'b1, mk(1, 7, 0, 1), 1'b1);
        beat(1'b1, 1'b0, 1'b0, mk(1, 7, 1, 0), 1'b1);
        beat(1'b1, 1'b0, 1'b1, mk(1, 7, 1, 1), 1'b1);
        chk("inj_restart_locked", locked, 1'b1);
        beat(1'b1, 1'b0, 1'b0, mk(1, 7, 2, 0), 1'b1);
        beat(1'b1, 1'b0, 1'b1, mk(1, 7, 2, 1), 1'b1);
        beat(1'b1, 1'b0, 1'b0, mk(1, 7, 3, 0), 1'b1);
        beat(1'b1, 1'b0, 1'b1, mk(1, 7, 3, 1), 1'b1);
        chk("inj_end_locked", locked, 1'b0);
        chk("inj_end_switch", switch_p, 1'b1);
        chk("inj_end_active", active_src, 1'b0);
        chk("inj_end_err_cnt", err_cnt, 16'h0001);

        // Error counter saturation: continuous tuser beats on source 0
        beat(1'b0, 1'b1, 1'b0, mk(0, 10, 0, 0), 1'b1);
        chk("sat_start_err", err_cnt, 16'h0001);
        drive(1'b0, 1'b1, 1'b1, 1'b0, mk(0, 10, 0, 1));
        repeat (65533) tick();
        chk("sat_fffe", err_cnt, 16'hFFFE);
        tick();
        chk("sat_ffff", err_cnt, 16'hFFFF);
        repeat (5) tick();
        chk("sat_hold", err_cnt, 16'hFFFF);
        chk("sat_locked", locked, 1'b1);
        for (int l = 0; l < 4; l++) beat(1'b0, 1'b0, 1'b1, mk(0, 10, l, 1), 1'b1);
        chk("sat_end_locked", locked, 1'b0);

        // Random downstream backpressure; source 1 busy but not selected
        v1_tvalid = 1'b1; v1_tuser = 1'b0; v1_tlast = 1'b0; v1_tdata = mk(1, 99, 0, 0);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 2; b++) begin
                d = mk(0, 11, l, b);
                v0_tvalid = 1'b1; v0_tuser = (l == 0 && b == 0); v0_tlast = (b == 1); v0_tdata = d;
                hs = 1'b0;
                for (int t = 0; t < 16 && !hs; t++) begin
                    o_tready = (t >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                    #1;
                    chk("bp_tvalid", o_tvalid, 1'b1);
                    chk("bp_tdata", o_tdata, d);
                    chk("bp_src_tready", v0_tready, o_tready);
                    chk("bp_drain_unsel", v1_tready, 1'b1);
                    chk("bp_stall_unsel", s_v1_tready, 1'b0);
                    chk("bp_stall_tdata", s_o_tdata, d);
                    hs = o_tready;
                    tick();
                end
            end
        end
        v0_tvalid = 1'b0; v1_tvalid = 1'b0; o_tready = 1'b1;
        chk("bp_end_locked", locked, 1'b0);

        // Reset mid-line, then resync on the next SOF
        beat(1'b0, 1'b1, 1'b0, mk(0, 12, 0, 0), 1'b1);
        beat(1'b0, 1'b0, 1'b1, mk(0, 12, 0, 1), 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, mk(0, 12, 1, 0));
        #1;
        chk("pre_rst_tvalid", o_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", o_tvalid, 1'b0);
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_tready", v0_tready, 1'b0);
        chk("midrst_err_cnt", err_cnt, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_idle_tvalid", o_tvalid, 1'b0);
        chk("postrst_idle_tready", v0_tready, 1'b0);
        tick();
        chk("postrst_active", active_src, 1'b0);
        beat(1'b0, 1'b0, 1'b1, mk(0, 12, 1, 1), 1'b0);
        frame(1'b0, 13, 1'b0, 1'b0);
        chk("resync_err_cnt", err_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
